// File: rtl/msgq_reader.sv
// msgq_reader
//   Drains a 64-entry flagless LUT-RAM word queue and frames its contents
//   into messages. Each message starts with a header word whose bits [5:0]
//   give the payload length L. The whole message is 1 + L words long.
//   The queue has no status flags, so occupancy is tracked here from the
//   producer's write strobe and the reads this block issues. A message is
//   only released once every one of its words is resident. This lets the
//   consumer take the message as one burst with no bubbles.
//
// Ports
//   clk, rst      system clock; synchronous active-high reset
//   q_wr_en       copy of the producer's write strobe into the queue
//   q_dout        queue read data (asynchronous read of current address)
//   q_rd_en       pops the queue read pointer
//   q_full        occupancy == 64; producer must hold off
//   occupancy     words resident in the queue, 0..64
//   out_valid     out_data carries a message word
//   out_ready     consumer accepts the word when out_valid is also high
//   out_data      message word, straight from q_dout
//   out_first     current word is the header
//   out_last      current word is the final word of the message
//   overflow      sticky: a write arrived while full with no read
module msgq_reader #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             q_wr_en,
  input  logic [width-1:0] q_dout,
  output logic             q_rd_en,
  output logic             q_full,
  output logic [6:0]       occupancy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic             out_first,
  output logic             out_last,
  output logic             overflow
);

  localparam logic [6:0] DEPTH = 7'd64;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  state_t     state_q, state_d;
  logic [6:0] occ_q, occ_d;
  logic [5:0] remaining_q, remaining_d;
  logic       first_q, first_d;
  logic       overflow_q, overflow_d;

  logic [6:0] msg_words;
  logic       accept;

  // Total words the header at the head of the queue claims (1..64).
  assign msg_words = {1'b0, q_dout[5:0]} + 7'd1;

  assign out_valid = (state_q == STREAM);
  assign accept    = out_valid & out_ready;

  assign q_rd_en   = accept;
  assign q_full    = (occ_q == DEPTH);
  assign occupancy = occ_q;
  assign out_data  = q_dout;
  assign out_first = first_q;
  assign out_last  = (state_q == STREAM) && (remaining_q == '0);
  assign overflow  = overflow_q;

  // Occupancy bookkeeping. A write while full with no read is lost. The
  // count saturates and the error is latched.
  always_comb begin
    occ_d      = occ_q;
    overflow_d = overflow_q;
    case ({q_wr_en, accept})
      2'b10: begin
        if (occ_q == DEPTH) overflow_d = 1'b1;
        else                occ_d      = occ_q + 7'd1;
      end
      2'b01:   occ_d = occ_q - 7'd1;
      default: ;
    endcase
  end

  // Framing. In IDLE the header is visible on q_dout whenever the queue is
  // non-empty. Nothing is read until the full message has arrived, so the
  // header stays stable while waiting.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    first_d     = first_q;
    case (state_q)
      IDLE: begin
        if ((occ_q != '0) && (occ_q >= msg_words)) begin
          state_d     = STREAM;
          remaining_d = q_dout[5:0];
          first_d     = 1'b1;
        end
      end
      STREAM: begin
        if (accept) begin
          first_d = 1'b0;
          if (remaining_q == '0) state_d     = IDLE;
          else                   remaining_d = remaining_q - 6'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= '0;
      remaining_q <= '0;
      first_q     <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      occ_q       <= occ_d;
      remaining_q <= remaining_d;
      first_q     <= first_d;
      overflow_q  <= overflow_d;
    end
  end

endmodule

// File: tb/tb_msgq_reader.sv
module tb_msgq_reader;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         q_wr_en = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] q_dout;
  logic         q_rd_en, q_full, out_valid, out_first, out_last, overflow;
  logic [6:0]   occupancy;
  logic [W-1:0] out_data;

  // Environment: the 64-entry flagless queue with asynchronous read.
  logic [W-1:0] mem [64];
  logic [5:0]   wp = '0, rp = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the words resident in the queue, how many there are,
  // and where the next accepted word falls within its message.
  logic [W-1:0] ref_q[$];
  int           ref_occ  = 0;
  bit           ref_ovf  = 0;
  bit           ref_hdr  = 1;
  int           ref_left = 0;

  always #5 clk = ~clk;

  msgq_reader #(.width(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .q_wr_en   (q_wr_en),
    .q_dout    (q_dout),
    .q_rd_en   (q_rd_en),
    .q_full    (q_full),
    .occupancy (occupancy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_first (out_first),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial for (int i = 0; i < 64; i++) mem[i] = '0;

  assign q_dout = mem[rp];

  always @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (q_wr_en) begin
        mem[wp] <= wr_data;
        wp      <= wp + 6'd1;
      end
      if (q_rd_en) rp <= rp + 6'd1;
    end
  end

  always @(posedge clk)
    if (!rst) assert (!(q_rd_en && occupancy == 7'd0))
      else begin n_fail++; $error("FAIL read_at_empty: q_rd_en=1 occupancy=0"); end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [W-1:0] mk_hdr(input int len);
    logic [W-1:0] r;
    r      = $urandom();
    r[5:0] = 6'(len);
    return r;
  endfunction

  function automatic bit exp_last();
    logic [W-1:0] h;
    h = ref_q[0];
    if (ref_hdr) return h[5:0] == 6'd0;
    return ref_left == 1;
  endfunction

  // Advance one clock. The model is updated with whatever the bench was
  // driving and whatever the DUT was accepting just before the edge.
  task automatic tick();
    bit           acc, wr;
    logic [W-1:0] w, h;
    acc = out_valid && out_ready;
    wr  = q_wr_en;
    w   = wr_data;
    @(posedge clk);
    if (rst) begin
      ref_q.delete();
      ref_occ = 0; ref_ovf = 0; ref_hdr = 1; ref_left = 0;
    end else begin
      if (acc && ref_q.size() > 0) begin
        h = ref_q.pop_front();
        if (ref_hdr) ref_left = int'(h[5:0]);
        else         ref_left = ref_left - 1;
        ref_hdr = (ref_left == 0);
      end
      if (wr && !acc && ref_occ == 64) ref_ovf = 1;
      else begin
        ref_occ = ref_occ + int'(wr) - int'(acc);
        if (wr) ref_q.push_back(w);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; q_wr_en = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (q_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", q_rd_en); end
    n_checks++; if (q_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", q_full); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    n_checks++; if (out_first !== 1'b0 || out_last !== 1'b0) begin n_fail++; $display("FAIL reset_first_last: got %b%b want 00", out_first, out_last); end
    n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_basic();
    logic [W-1:0] words [4];
    words[0] = mk_hdr(3);
    for (int i = 1; i < 4; i++) words[i] = $urandom();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      q_wr_en = 1'b1; wr_data = words[i];
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: valid during write %0d", i); end
      tick();
    end
    q_wr_en = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_lat1: got %b want 0 one cycle after last write", out_valid); end
    tick(); #1;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== words[i] || out_first !== (i == 0) || out_last !== (i == 3)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got v%b %h f%b l%b want v1 %h f%0b l%0b",
                 i, out_valid, out_data, out_first, out_last, words[i], i == 0, i == 3);
      end
      tick(); #1;
    end
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 7'd0) begin n_fail++; $display("FAIL basic_end: got v%b occ %0d want v0 occ 0", out_valid, occupancy); end
  endtask

  task automatic test_partial();
    out_ready = 1'b1;
    q_wr_en = 1'b1; wr_data = mk_hdr(2); tick();
    wr_data = $urandom(); tick();
    q_wr_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_wait: valid at wait cycle %0d", i); end
      tick();
    end
    #1;
    n_checks++; if (occupancy !== 7'(ref_occ) || ref_occ != 2) begin n_fail++; $display("FAIL partial_occ: got %0d want 2", occupancy); end
    q_wr_en = 1'b1; wr_data = $urandom(); tick();
    q_wr_en = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL partial_lat1: got %b want 0", out_valid); end
    tick(); #1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (ref_q.size() == 0) begin n_fail++; $display("FAIL partial_word%0d: model empty", i); end
      else if (out_valid !== 1'b1 || out_data !== ref_q[0] || out_first !== ref_hdr || out_last !== exp_last()) begin
        n_fail++;
        $display("FAIL partial_word%0d: got v%b %h f%b l%b want v1 %h f%0b l%0b",
                 i, out_valid, out_data, out_first, out_last, ref_q[0], ref_hdr, exp_last());
      end
      tick(); #1;
    end
    n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL partial_end_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_zero_len();
    logic [W-1:0] h [2];
    bit exp_v [5];
    h[0] = mk_hdr(0); h[1] = mk_hdr(0);
    exp_v[0] = 0; exp_v[1] = 1; exp_v[2] = 0; exp_v[3] = 1; exp_v[4] = 0;
    out_ready = 1'b1;
    q_wr_en = 1'b1; wr_data = h[0]; tick();
    for (int c = 0; c < 5; c++) begin
      q_wr_en = (c == 0); wr_data = h[1];
      #1;
      n_checks++;
      if (out_valid !== exp_v[c] ||
          (exp_v[c] && (out_data !== h[c/2] || out_first !== 1'b1 || out_last !== 1'b1))) begin
        n_fail++;
        $display("FAIL zero_cycle%0d: got v%b %h f%b l%b want v%0b %h f1 l1",
                 c, out_valid, out_data, out_first, out_last, exp_v[c], h[c/2]);
      end
      tick();
    end
    q_wr_en = 1'b0;
  endtask

  task automatic test_stall();
    logic [W-1:0] wq[$];
    logic [W-1:0] prev_data;
    bit  prev_valid, prev_ready, prev_first, prev_last;
    int  reads, msg1_reads, done, cyc;
    out_ready = 1'b0;
    q_wr_en = 1'b1; wr_data = mk_hdr(5); tick();
    for (int i = 0; i < 5; i++) begin wr_data = $urandom(); tick(); end
    q_wr_en = 1'b0;
    wq.push_back(mk_hdr(2)); wq.push_back($urandom()); wq.push_back($urandom());
    for (int i = 0; i < 10 && !out_valid; i++) begin tick(); #1; end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_start: got %b want 1", out_valid); end
    reads = 0; msg1_reads = 0; done = 0; cyc = 0; prev_valid = 0;
    while (done < 2 && cyc < 200) begin
      out_ready = (cyc % 3 == 0);
      q_wr_en = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
      if (q_wr_en) wr_data = wq.pop_front();
      #1;
      n_checks++; if (occupancy !== 7'(ref_occ)) begin n_fail++; $display("FAIL stall_occ: got %0d want %0d", occupancy, ref_occ); end
      if (out_valid) begin
        n_checks++;
        if (ref_q.size() == 0) begin n_fail++; $display("FAIL stall_word: valid with model empty"); end
        else if (out_data !== ref_q[0] || out_first !== ref_hdr || out_last !== exp_last()) begin
          n_fail++;
          $display("FAIL stall_word: got %h f%b l%b want %h f%0b l%0b",
                   out_data, out_first, out_last, ref_q[0], ref_hdr, exp_last());
        end
        if (prev_valid && !prev_ready) begin
          n_checks++;
          if (out_data !== prev_data || out_first !== prev_first || out_last !== prev_last) begin
            n_fail++;
            $display("FAIL stall_hold: got %h f%b l%b want %h f%0b l%0b",
                     out_data, out_first, out_last, prev_data, prev_first, prev_last);
          end
        end
      end
      if (q_rd_en) begin
        reads++;
        if (out_last) begin
          done++;
          if (done == 1) msg1_reads = reads;
        end
      end
      prev_valid = out_valid; prev_ready = out_ready; prev_data = out_data;
      prev_first = out_first; prev_last = out_last;
      tick();
      cyc++;
    end
    q_wr_en = 1'b0;
    #1;
    n_checks++; if (done != 2) begin n_fail++; $display("FAIL stall_done: got %0d messages want 2", done); end
    n_checks++; if (msg1_reads != 6) begin n_fail++; $display("FAIL stall_reads: got %0d reads want 6", msg1_reads); end
    n_checks++; if (occupancy !== 7'd0) begin n_fail++; $display("FAIL stall_end_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_full_overflow();
    out_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      q_wr_en = 1'b1; wr_data = (i == 0) ? mk_hdr(63) : W'($urandom());
      #1;
      if (i == 63) begin
        n_checks++; if (q_full !== 1'b0 || occupancy !== 7'd63) begin n_fail++; $display("FAIL full_63: got full %b occ %0d want full 0 occ 63", q_full, occupancy); end
      end
      tick();
    end
    q_wr_en = 1'b0;
    #1;
    n_checks++; if (q_full !== 1'b1 || occupancy !== 7'd64) begin n_fail++; $display("FAIL full_64: got full %b occ %0d want full 1 occ 64", q_full, occupancy); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
    q_wr_en = 1'b1; wr_data = $urandom(); tick();
    q_wr_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_checks++;
      if (overflow !== ref_ovf || ref_ovf != 1 || occupancy !== 7'd64) begin
        n_fail++;
        $display("FAIL ovf_sticky%0d: got ovf %b occ %0d want ovf 1 occ 64", i, overflow, occupancy);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; #1;
    n_checks++; if (overflow !== 1'b0 || occupancy !== 7'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_clear: got ovf %b occ %0d v %b want 0 0 0", overflow, occupancy, out_valid); end
    q_wr_en = 1'b1; wr_data = mk_hdr(4); tick();
    for (int i = 0; i < 4; i++) begin wr_data = $urandom(); tick(); end
    q_wr_en = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin tick(); #1; end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (ref_q.size() == 0) begin n_fail++; $display("FAIL rstmid_word%0d: model empty", i); end
      else if (out_valid !== 1'b1 || out_data !== ref_q[0] || out_first !== ref_hdr) begin
        n_fail++;
        $display("FAIL rstmid_word%0d: got v%b %h f%b want v1 %h f%0b", i, out_valid, out_data, out_first, ref_q[0], ref_hdr);
      end
      tick();
    end
    rst = 1'b1; tick();
    rst = 1'b0; #1;
    n_checks++; if (out_valid !== 1'b0 || occupancy !== 7'd0) begin n_fail++; $display("FAIL rstmid_after: got v%b occ %0d want v0 occ 0", out_valid, occupancy); end
    q_wr_en = 1'b1; wr_data = mk_hdr(1); tick();
    wr_data = $urandom(); tick();
    q_wr_en = 1'b0;
    for (int i = 0; i < 10 && !out_valid; i++) begin tick(); #1; end
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (ref_q.size() == 0) begin n_fail++; $display("FAIL rstmid_fresh%0d: model empty", i); end
      else if (out_valid !== 1'b1 || out_data !== ref_q[0] || out_first !== (i == 0) || out_last !== (i == 1)) begin
        n_fail++;
        $display("FAIL rstmid_fresh%0d: got v%b %h f%b l%b want v1 %h f%0b l%0b",
                 i, out_valid, out_data, out_first, out_last, ref_q[0], i == 0, i == 1);
      end
      tick();
    end
    #1;
    n_checks++; if (occupancy !== 7'd0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_end: got occ %0d v%b want 0 0", occupancy, out_valid); end
  endtask

  task automatic test_random();
    logic [W-1:0] wq[$];
    logic [W-1:0] h;
    int nmsg, done, cyc, len;
    nmsg = 30;
    for (int m = 0; m < nmsg; m++) begin
      len = (m == 17) ? 63 : int'($urandom_range(0, 12));
      wq.push_back(mk_hdr(len));
      for (int i = 0; i < len; i++) wq.push_back($urandom());
    end
    done = 0; cyc = 0;
    while (done < nmsg && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      q_wr_en = (wq.size() > 0) && (ref_occ < 64) && ($urandom_range(0, 2) != 0);
      if (q_wr_en) wr_data = wq.pop_front();
      #1;
      n_checks++;
      if (occupancy !== 7'(ref_occ) || q_full !== (ref_occ == 64)) begin
        n_fail++;
        $display("FAIL rand_occ: got occ %0d full %b want occ %0d full %0b", occupancy, q_full, ref_occ, ref_occ == 64);
      end
      if (out_valid) begin
        n_checks++;
        if (ref_q.size() == 0) begin n_fail++; $display("FAIL rand_word: valid with model empty"); end
        else begin
          h = ref_q[0];
          if (out_data !== h || out_first !== ref_hdr || out_last !== exp_last()) begin
            n_fail++;
            $display("FAIL rand_word: got %h f%b l%b want %h f%0b l%0b",
                     out_data, out_first, out_last, h, ref_hdr, exp_last());
          end
          if (ref_hdr && ref_q.size() < int'(h[5:0]) + 1) begin
            n_fail++;
            $display("FAIL rand_resident: header released with %0d words resident want %0d", ref_q.size(), int'(h[5:0]) + 1);
          end
        end
      end
      if (q_rd_en && out_last) done++;
      tick();
      cyc++;
    end
    q_wr_en = 1'b0;
    #1;
    n_checks++; if (done != nmsg) begin n_fail++; $display("FAIL rand_done: got %0d messages want %0d", done, nmsg); end
    n_checks++; if (occupancy !== 7'd0 || ref_q.size() != 0) begin n_fail++; $display("FAIL rand_end: got occ %0d model %0d want 0 0", occupancy, ref_q.size()); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_partial();
    test_zero_len();
    test_stall();
    test_full_overflow();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
